fadd_ctrl: RTL

FADD_CTRL -- requirements
Module: fadd_ctrl

---
 rtl/fadd_pkg.sv | 24 ++
 rtl/fadd_special_detect.sv | 28 ++
 rtl/fadd_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fadd_pkg.sv
// Shared types and constants for the floating-point adder sequencer.
package fadd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_PACK,
        S_DONE
    } state_t;

    localparam logic [1:0] RES_NORMAL = 2'b00;
    localparam logic [1:0] RES_ZERO   = 2'b01;
    localparam logic [1:0] RES_INF    = 2'b10;
    localparam logic [1:0] RES_NAN    = 2'b11;

    localparam logic [7:0] EXP_MAX = 8'd255;

    localparam int unsigned MAX_ALIGN_DEF = 25;
    localparam int unsigned MAX_NORM_DEF  = 24;

endpackage

// File: rtl/fadd_special_detect.sv
// Flags operand pairs that bypass the add path (an all-ones exponent) and
// selects the infinity or NaN result code for them.
module fadd_special_detect
    import fadd_pkg::*;
(
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic        o_is_special,
    output logic [1:0]  o_res_sel
);

    logic w_x_max;
    logic w_y_max;
    logic w_x_nan;
    logic w_y_nan;
    logic w_inf_cancel;

    assign w_x_max      = (i_x[30:23] == EXP_MAX);
    assign w_y_max      = (i_y[30:23] == EXP_MAX);
    assign w_x_nan      = w_x_max && (i_x[22:0] != 23'd0);
    assign w_y_nan      = w_y_max && (i_y[22:0] != 23'd0);
    // Opposite-signed infinities have no defined sum.
    assign w_inf_cancel = w_x_max && w_y_max && (i_x[31] ^ i_y[31]);

    assign o_is_special = w_x_max || w_y_max;
    assign o_res_sel    = (w_x_nan || w_y_nan || w_inf_cancel) ? RES_NAN : RES_INF;

endmodule

// File: rtl/fadd_ctrl.sv
// Control FSM for a multi-cycle IEEE-754 single-precision adder: sequences
// load, align, add, normalize and pack strobes for an external datapath.
module fadd_ctrl
    import fadd_pkg::*;
#(
    parameter int unsigned MAX_ALIGN = MAX_ALIGN_DEF,
    parameter int unsigned MAX_NORM  = MAX_NORM_DEF
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        sum_ovf,
    input  logic        sum_msb,
    input  logic        sum_zero,
    output logic        swap_sel,
    output logic        load_en,
    output logic        shr_en,
    output logic        add_en,
    output logic        norm_r_en,
    output logic        norm_l_en,
    output logic        pack_en,
    output logic        sub_op,
    output logic [1:0]  res_sel,
    output logic [7:0]  exp_out,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] ALIGN_CAP = 8'(MAX_ALIGN);
    localparam logic [7:0] NORM_LAST = 8'(MAX_NORM - 1);
    localparam logic [7:0] EXP_PRE   = EXP_MAX - 8'd1;

    state_t      r_state;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [7:0]  r_cnt;
    logic [7:0]  r_nrm;

    logic        w_big_y;
    logic [7:0]  w_exp_big;
    logic [7:0]  w_exp_small;
    logic [7:0]  w_diff;
    logic [7:0]  w_cnt;
    logic        w_is_special;
    logic [1:0]  w_special_sel;
    logic        w_flush;

    // Magnitude compare on the raw bit pattern orders by exponent, then fraction.
    assign w_big_y     = (y[30:0] > x[30:0]);
    assign w_exp_big   = w_big_y ? y[30:23] : x[30:23];
    assign w_exp_small = w_big_y ? x[30:23] : y[30:23];
    assign w_diff      = w_exp_big - w_exp_small;
    assign w_cnt       = (w_diff > ALIGN_CAP) ? ALIGN_CAP : w_diff;

    fadd_special_detect u_special (
        .i_x          (r_x),
        .i_y          (r_y),
        .o_is_special (w_is_special),
        .o_res_sel    (w_special_sel)
    );

    // Normalize strobes act on the sum flags of the current cycle, so they
    // are decoded rather than registered to keep NORM a single-cycle decision.
    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        norm_r_en = 1'b0;
        norm_l_en = 1'b0;
        w_flush   = 1'b0;
        if (r_state == S_NORM && !sum_zero) begin
            if (sum_ovf) begin
                norm_r_en = 1'b1;
            end else if (!sum_msb) begin
                if (exp_out == 8'd1 || r_nrm == NORM_LAST) begin
                    w_flush = 1'b1;
                end else begin
                    norm_l_en = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_nrm    <= '0;
            swap_sel <= 1'b0;
            load_en  <= 1'b0;
            shr_en   <= 1'b0;
            add_en   <= 1'b0;
            pack_en  <= 1'b0;
            sub_op   <= 1'b0;
            res_sel  <= RES_NORMAL;
            exp_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            load_en <= 1'b0;
            shr_en  <= 1'b0;
            add_en  <= 1'b0;
            pack_en <= 1'b0;
            done    <= 1'b0;
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_x      <= x;
                    r_y      <= y;
                    swap_sel <= w_big_y;
                    exp_out  <= w_exp_big;
                    sub_op   <= x[31] ^ y[31];
                    r_cnt    <= w_cnt;
                    r_nrm    <= '0;
                    res_sel  <= RES_NORMAL;
                    load_en  <= 1'b1;
                    busy     <= 1'b1;
                    r_state  <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_is_special) begin
                        res_sel <= w_special_sel;
                        pack_en <= 1'b1;
                        r_state <= S_PACK;
                    end else if (r_cnt == 8'd0) begin
                        add_en  <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        shr_en  <= 1'b1;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        add_en  <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        shr_en  <= 1'b1;
                    end
                end
                S_ADD: r_state <= S_NORM;
                S_NORM: begin
                    if (sum_zero) begin
                        res_sel <= RES_ZERO;
                        pack_en <= 1'b1;
                        r_state <= S_PACK;
                    end else if (sum_ovf) begin
                        exp_out <= exp_out + 8'd1;
                        if (exp_out == EXP_PRE) res_sel <= RES_INF;
                        pack_en <= 1'b1;
                        r_state <= S_PACK;
                    end else if (sum_msb || w_flush) begin
                        if (w_flush) res_sel <= RES_ZERO;
                        pack_en <= 1'b1;
                        r_state <= S_PACK;
                    end else begin
                        exp_out <= exp_out - 8'd1;
                        r_nrm   <= r_nrm + 8'd1;
                    end
                end
                S_PACK: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    swap_sel <= 1'b0;
                    sub_op   <= 1'b0;
                    res_sel  <= RES_NORMAL;
                    exp_out  <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
